// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding and operation modes.
package serial_alu_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_fa_cell.sv
// Single-bit full adder; purely combinational, shared by the serial datapath blocks.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub_unit.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB first; done pulses WIDTH cycles after an accepted start.
// start is ignored while busy; a start seen in DONE begins the next operation back-to-back.
module serial_addsub_unit
  import serial_alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic [CNT_W-1:0] count;
  logic             carry;
  logic             fa_s;
  logic             fa_co;
  logic             c_msb;
  logic [WIDTH-1:0] res_next;

  serial_fa_cell u_fa (
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_co)
  );

  // On the final step the live carry is the carry into the MSB.
  assign c_msb    = carry;
  assign res_next = {fa_s, res[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      count <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            // Subtraction is A + ~B + 1, the +1 entering as the initial carry.
            sb    <= (sub == MODE_SUB) ? ~b : b;
            carry <= sub;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          res   <= res_next;
          carry <= fa_co;
          count <= count + CNT_W'(1);
          if (count == LAST) begin
            sum   <= res_next;
            cout  <= fa_co;
            ovf   <= c_msb ^ fa_co;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
